// File: rtl/clk_tick_pkg.sv
// clk_tick_pkg: shared constants and width helper for the multi-channel tick generator
package clk_tick_pkg;
  localparam int CNT_W_DEFAULT = 16;
  localparam int DIV_DEFAULT = 10000;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_tick_chan.sv
// clk_tick_chan: one tick channel with pending divisor; TICK_SQUARE_OUT_EN builds the square-wave toggle
module clk_tick_chan
  import clk_tick_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int DIV_DEFAULT = clk_tick_pkg::DIV_DEFAULT
)(
  input  logic             clkI,
  input  logic             nRstI,
  input  logic             i_working,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_div,
  input  logic             i_sync,
  output logic             o_tick,
  output logic             o_sq
);
  logic [CNT_W-1:0] r_cnt, r_div, r_pend, w_next_div;
  logic r_pend_v, r_tick, w_reload, w_fire;
  // a write in the same cycle as a reload/sync/idle is applied immediately
  assign w_next_div = i_wr ? i_wr_div : (r_pend_v ? r_pend : r_div);
  assign w_reload = ~i_working | i_sync | (r_cnt == '0);
  assign w_fire = i_working & ~i_sync & (r_cnt == '0);
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      r_cnt <= CNT_W'(DIV_DEFAULT - 1);
      r_div <= CNT_W'(DIV_DEFAULT);
      r_pend <= '0;
      r_pend_v <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_fire;
      if (w_reload) begin
        r_div <= w_next_div;
        r_cnt <= w_next_div - CNT_W'(1);
        r_pend_v <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (i_wr) begin
          r_pend <= i_wr_div;
          r_pend_v <= 1'b1;
        end
      end
    end
  end
  assign o_tick = r_tick;
`ifdef TICK_SQUARE_OUT_EN
  logic r_sq;
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) r_sq <= 1'b0;
    else r_sq <= (~i_working | i_sync) ? 1'b0 : r_sq ^ w_fire;
  end
  assign o_sq = r_sq;
`else
  assign o_sq = 1'b0;
`endif
endmodule

// File: rtl/clk_tick_gen_multi.sv
// clk_tick_gen_multi: multi-channel programmable tick generator with write decode, error flag and sync fan-out
// Optional square-wave outputs are built when TICK_SQUARE_OUT_EN is defined.
module clk_tick_gen_multi
  import clk_tick_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int DIV_DEFAULT = clk_tick_pkg::DIV_DEFAULT,
  localparam int CH_W = ch_w(CH_NUM)
)(
  input  logic              clkI,
  input  logic              nRstI,
  input  logic [CH_NUM-1:0] workingI,
  input  logic              wrEnI,
  input  logic [CH_W-1:0]   wrChI,
  input  logic [CNT_W-1:0]  wrDivI,
  input  logic              syncI,
  output logic [CH_NUM-1:0] tickO,
  output logic [CH_NUM-1:0] sqO,
  output logic              errO
);
  logic w_bad, r_err;
  logic [CH_NUM-1:0] w_wr;
  assign w_bad = (wrDivI == '0) || (32'(wrChI) >= CH_NUM);
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) r_err <= 1'b0;
    else r_err <= wrEnI & w_bad;
  end
  assign errO = r_err;
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    assign w_wr[i] = wrEnI & ~w_bad & (32'(wrChI) == i);
    clk_tick_chan #(.CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEFAULT)) u_chan (
      .clkI      (clkI),
      .nRstI     (nRstI),
      .i_working (workingI[i]),
      .i_wr      (w_wr[i]),
      .i_wr_div  (wrDivI),
      .i_sync    (syncI),
      .o_tick    (tickO[i]),
      .o_sq      (sqO[i])
    );
  end
endmodule

// File: tb/tb_clk_tick_gen_multi.sv
// tb_clk_tick_gen_multi: table-driven directed check of the tick generator plus reset/square-wave sequences
module tb_clk_tick_gen_multi;
  logic clkI = 1'b0, nRstI = 1'b0;
  logic [3:0] workingI = '0, tickO, sqO;
  logic wrEnI = 1'b0, syncI = 1'b0, errO, err3;
  logic [1:0] wrChI = '0;
  logic [15:0] wrDivI = '0;
  logic [2:0] tick3, sq3;
  int n_vec = 0, n_err = 0;

  always #5 clkI = ~clkI;

  clk_tick_gen_multi dut (
    .clkI(clkI), .nRstI(nRstI), .workingI(workingI), .wrEnI(wrEnI), .wrChI(wrChI),
    .wrDivI(wrDivI), .syncI(syncI), .tickO(tickO), .sqO(sqO), .errO(errO));
  // three-channel instance makes wrChI == CH_NUM reachable
  clk_tick_gen_multi #(.CH_NUM(3)) dut3 (
    .clkI(clkI), .nRstI(nRstI), .workingI(workingI[2:0]), .wrEnI(wrEnI), .wrChI(wrChI),
    .wrDivI(wrDivI), .syncI(syncI), .tickO(tick3), .sqO(sq3), .errO(err3));

  typedef struct {
    int rep; logic [3:0] wk; logic wr; logic [1:0] ch; logic [15:0] dv; logic sy;
    logic [3:0] et; logic ee; logic ee3;
  } vec_t;
  vec_t v[$];

  function automatic void a(input int rep, input logic [3:0] wk, input logic wr, input logic [1:0] ch,
                            input logic [15:0] dv, input logic sy, input logic [3:0] et,
                            input logic ee, input logic ee3);
    v.push_back(vec_t'{rep, wk, wr, ch, dv, sy, et, ee, ee3});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] wk, input logic wr, input logic [1:0] ch,
                       input logic [15:0] dv, input logic sy);
    workingI = wk; wrEnI = wr; wrChI = ch; wrDivI = dv; syncI = sy;
    @(posedge clkI);
    #1;
  endtask

  initial begin
    // T1: default divisor on ch0
    a(9999, 4'h1, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h1, 0, 0, 0, 0, 4'h1, 0, 0);
    a(9999, 4'h1, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h1, 0, 0, 0, 0, 4'h1, 0, 0);
    a(1, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
    // T2: idle write ch1 div 5
    a(1, 4'h0, 1, 1, 5, 0, 4'h0, 0, 0);
    a(4, 4'h2, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h2, 0, 0, 0, 0, 4'h2, 0, 0);
    a(4, 4'h2, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h2, 0, 0, 0, 0, 4'h2, 0, 0);
    a(4, 4'h2, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h2, 0, 0, 0, 0, 4'h2, 0, 0);
    a(1, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
    // div == 1: tick every cycle
    a(1, 4'h0, 1, 1, 1, 0, 4'h0, 0, 0);
    a(1, 4'h2, 0, 0, 0, 0, 4'h2, 0, 0); a(1, 4'h2, 0, 0, 0, 0, 4'h2, 0, 0);
    a(1, 4'h2, 0, 0, 0, 0, 4'h2, 0, 0); a(1, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
    // working drops mid-period: full restart, no partial tick
    a(1, 4'h0, 1, 1, 5, 0, 4'h0, 0, 0);
    a(3, 4'h2, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
    a(4, 4'h2, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h2, 0, 0, 0, 0, 4'h2, 0, 0);
    // write + sync same cycle, then sync on cnt==0
    a(2, 4'h2, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h2, 1, 1, 2, 1, 4'h0, 0, 0);
    a(1, 4'h2, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h2, 0, 0, 0, 0, 4'h2, 0, 0);
    a(1, 4'h2, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h2, 0, 0, 0, 0, 4'h2, 0, 0);
    a(1, 4'h2, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h2, 0, 0, 0, 1, 4'h0, 0, 0);
    a(1, 4'h2, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h2, 0, 0, 0, 0, 4'h2, 0, 0);
    a(1, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
    // T3: ch2 div 8, write 3 mid-period
    a(1, 4'h0, 1, 2, 8, 0, 4'h0, 0, 0);
    a(3, 4'h4, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h4, 1, 2, 3, 0, 4'h0, 0, 0);
    a(3, 4'h4, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h4, 0, 0, 0, 0, 4'h4, 0, 0);
    a(2, 4'h4, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h4, 0, 0, 0, 0, 4'h4, 0, 0);
    a(2, 4'h4, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h4, 0, 0, 0, 0, 4'h4, 0, 0);
    a(1, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
    // T4: ch0/ch3 out of phase, sync realigns
    a(1, 4'h0, 1, 0, 6, 0, 4'h0, 0, 0); a(1, 4'h0, 1, 3, 6, 0, 4'h0, 0, 1);
    a(2, 4'h1, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h9, 0, 0, 0, 0, 4'h0, 0, 0);
    a(1, 4'h9, 0, 0, 0, 1, 4'h0, 0, 0);
    a(5, 4'h9, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h9, 0, 0, 0, 0, 4'h9, 0, 0);
    a(5, 4'h9, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h9, 0, 0, 0, 0, 4'h9, 0, 0);
    a(1, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
    // T5: rejected writes, ch0 divisor still 6
    a(1, 4'h0, 1, 0, 0, 0, 4'h0, 1, 1); a(1, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
    a(1, 4'h0, 1, 3, 9, 0, 4'h0, 0, 1); a(1, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
    a(5, 4'h1, 0, 0, 0, 0, 4'h0, 0, 0); a(1, 4'h1, 0, 0, 0, 0, 4'h1, 0, 0);
    a(1, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);

    repeat (3) @(posedge clkI);
    #1;
    n_vec++;
    chk("rst_hold_tick", 32'(tickO), 0);
    chk("rst_hold_err", 32'(errO), 0);
    @(negedge clkI) nRstI = 1'b1;
    #1;
    n_vec++;
    chk("rst_tick", 32'(tickO), 0);
    chk("rst_sq", 32'(sqO), 0);
    chk("rst_err", 32'({err3, errO}), 0);

    foreach (v[r]) begin
      for (int k = 0; k < v[r].rep; k++) begin
        drive(v[r].wk, v[r].wr, v[r].ch, v[r].dv, v[r].sy);
        if (k < v[r].rep - 1) begin
          if (tickO !== 4'h0 || errO !== 1'b0 || err3 !== 1'b0) begin
            n_err++;
            $display("FAIL vec%0d_quiet cyc%0d: got tick=%h err=%b err3=%b expected 0", r, k, tickO, errO, err3);
          end
        end else begin
          chk($sformatf("vec%0d_tick", r), 32'(tickO), 32'(v[r].et));
          chk($sformatf("vec%0d_err", r), 32'(errO), 32'(v[r].ee));
          chk($sformatf("vec%0d_err3", r), 32'(err3), 32'(v[r].ee3));
`ifndef TICK_SQUARE_OUT_EN
          chk($sformatf("vec%0d_sq", r), 32'(sqO), 0);
`endif
        end
      end
      n_vec++;
    end

    // T6: ch2 div 4 square wave, then async reset mid-run
    drive(4'h0, 1, 2, 4, 0);
    for (int e = 1; e <= 12; e++) begin
      drive(4'h4, 0, 0, 0, 0);
      n_vec++;
      chk($sformatf("t6_tick_e%0d", e), 32'(tickO), (e % 4 == 0) ? 32'h4 : 32'h0);
`ifdef TICK_SQUARE_OUT_EN
      chk($sformatf("t6_sq_e%0d", e), 32'(sqO), ((e / 4) % 2 == 1) ? 32'h4 : 32'h0);
`else
      chk($sformatf("t6_sq_e%0d", e), 32'(sqO), 0);
`endif
    end
    #2 nRstI = 1'b0;
    #1;
    n_vec++;
    chk("t6_rst_tick", 32'(tickO), 0);
    chk("t6_rst_sq", 32'(sqO), 0);
    @(negedge clkI) nRstI = 1'b1;
    for (int e = 1; e <= 10000; e++) begin
      drive(4'h4, 0, 0, 0, 0);
      if (e == 10000 || tickO !== 4'h0) begin
        n_vec++;
        chk($sformatf("t6_default_e%0d", e), 32'(tickO), (e == 10000) ? 32'h4 : 32'h0);
      end
    end
    drive(4'h0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
